// File: rtl/fetch_controller_if.sv
// fetch_controller_if: bundles the redirect, instruction-memory and
// instruction-delivery signals of the fetch controller.
// master = fetch controller side, slave = surrounding core/memory side.
// The fetch_misaligned signal exists only when FETCH_MISALIGN_TRAP_EN is defined.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

interface fetch_controller_if;
    logic                     redirect_valid;
    logic [`DATA_WIDTH-1:0]   redirect_pc;
    logic                     imem_req;
    logic [`DATA_WIDTH-1:0]   imem_addr;
    logic                     imem_ack;
    logic [`DATA_WIDTH-1:0]   imem_rdata;
    logic                     instr_valid;
    logic                     instr_ready;
    logic [`DATA_WIDTH-1:0]   instr_out;
    logic [`DATA_WIDTH-1:0]   instr_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic                     fetch_misaligned;

    modport master (
        input  redirect_valid, redirect_pc, imem_ack, imem_rdata, instr_ready,
        output imem_req, imem_addr, instr_valid, instr_out, instr_pc, fetch_misaligned
    );
    modport slave (
        output redirect_valid, redirect_pc, imem_ack, imem_rdata, instr_ready,
        input  imem_req, imem_addr, instr_valid, instr_out, instr_pc, fetch_misaligned
    );
`else
    modport master (
        input  redirect_valid, redirect_pc, imem_ack, imem_rdata, instr_ready,
        output imem_req, imem_addr, instr_valid, instr_out, instr_pc
    );
    modport slave (
        output redirect_valid, redirect_pc, imem_ack, imem_rdata, instr_ready,
        input  imem_req, imem_addr, instr_valid, instr_out, instr_pc
    );
`endif
endinterface

// File: rtl/fetch_controller.sv
// fetch_controller: single-outstanding-request instruction fetch unit.
// Issues one imem request at a time, holds the returned word until the
// downstream stage accepts it, and restarts at redirect targets.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (misaligned redirect
// target halts fetch and pulses fetch_misaligned). Without it, the low two
// bits of a redirect target are cleared when loaded.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module fetch_controller #(
    parameter logic [`DATA_WIDTH-1:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst_n,
    fetch_controller_if.master bus
);
    localparam int W = `DATA_WIDTH;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_REQ   = 2'b01;
    localparam logic [1:0] ST_HOLD  = 2'b10;
    localparam logic [1:0] ST_FLUSH = 2'b11;

    localparam logic [W-1:0] ALIGN_MASK = {{(W-2){1'b1}}, 2'b00};
    localparam logic [W-1:0] PC_STEP    = {{(W-3){1'b0}}, 3'b100};

    // Sequential successor; the add wraps modulo 2^W by construction.
    function automatic logic [W-1:0] seq_pc(input logic [W-1:0] pc);
        return pc + PC_STEP;
    endfunction

    // Word-align a redirect target.
    function automatic logic [W-1:0] align_pc(input logic [W-1:0] pc);
        return pc & ALIGN_MASK;
    endfunction

    logic [1:0]   state_r;
    logic [1:0]   state_nxt_s;
    logic [W-1:0] fetch_pc_r;
    logic [W-1:0] fetch_pc_nxt_s;
    logic [W-1:0] instr_out_r;
    logic [W-1:0] instr_out_nxt_s;
    logic [W-1:0] instr_pc_r;
    logic [W-1:0] instr_pc_nxt_s;
    logic         imem_req_r;
    logic [W-1:0] imem_addr_r;
    logic [W-1:0] imem_addr_nxt_s;
    logic         instr_valid_r;
    logic         halted_r;
    logic         halted_nxt_s;
    logic         redir_bad_s;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic         misaligned_r;

    // A redirect to a non-word-aligned target is a trap, not a fetch target.
    always_comb begin
        redir_bad_s = bus.redirect_valid & (bus.redirect_pc[1:0] != 2'b00);
    end
`else
    // Without the trap feature every redirect is usable (low bits are cleared).
    always_comb begin
        redir_bad_s = 1'b0;
    end
`endif

    // Next-state, next-PC and capture logic; redirect outranks ack and transfer.
    always_comb begin
        state_nxt_s     = state_r;
        fetch_pc_nxt_s  = fetch_pc_r;
        instr_out_nxt_s = instr_out_r;
        instr_pc_nxt_s  = instr_pc_r;
        halted_nxt_s    = halted_r;
        if (redir_bad_s) begin
            state_nxt_s  = ST_IDLE;
            halted_nxt_s = 1'b1;
        end else if (bus.redirect_valid) begin
            fetch_pc_nxt_s = align_pc(bus.redirect_pc);
            halted_nxt_s   = 1'b0;
            case (state_r)
                ST_REQ, ST_FLUSH: begin
                    if (bus.imem_ack) begin
                        state_nxt_s = ST_REQ;
                    end else begin
                        state_nxt_s = ST_FLUSH;
                    end
                end
                default: state_nxt_s = ST_REQ;
            endcase
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (halted_r) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (bus.imem_ack) begin
                        instr_out_nxt_s = bus.imem_rdata;
                        instr_pc_nxt_s  = fetch_pc_r;
                        state_nxt_s     = ST_HOLD;
                    end else begin
                        state_nxt_s = ST_REQ;
                    end
                end
                ST_HOLD: begin
                    if (bus.instr_ready) begin
                        fetch_pc_nxt_s = seq_pc(fetch_pc_r);
                        state_nxt_s    = ST_REQ;
                    end else begin
                        state_nxt_s = ST_HOLD;
                    end
                end
                ST_FLUSH: begin
                    if (bus.imem_ack) begin
                        state_nxt_s = ST_REQ;
                    end else begin
                        state_nxt_s = ST_FLUSH;
                    end
                end
                default: state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // A fresh request presents the new fetch PC; a flush keeps the old address.
    always_comb begin
        if (state_nxt_s == ST_REQ) begin
            imem_addr_nxt_s = fetch_pc_nxt_s;
        end else begin
            imem_addr_nxt_s = imem_addr_r;
        end
    end

    // State and registered outputs; reset abandons any request in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            fetch_pc_r    <= RESET_VECTOR;
            instr_out_r   <= {W{1'b0}};
            instr_pc_r    <= {W{1'b0}};
            imem_req_r    <= 1'b0;
            imem_addr_r   <= {W{1'b0}};
            instr_valid_r <= 1'b0;
            halted_r      <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            fetch_pc_r    <= fetch_pc_nxt_s;
            instr_out_r   <= instr_out_nxt_s;
            instr_pc_r    <= instr_pc_nxt_s;
            imem_req_r    <= (state_nxt_s == ST_REQ) || (state_nxt_s == ST_FLUSH);
            imem_addr_r   <= imem_addr_nxt_s;
            instr_valid_r <= (state_nxt_s == ST_HOLD);
            halted_r      <= halted_nxt_s;
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    // One-cycle trap pulse following a misaligned redirect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misaligned_r <= 1'b0;
        end else begin
            misaligned_r <= redir_bad_s;
        end
    end

    assign bus.fetch_misaligned = misaligned_r;
`endif

    assign bus.imem_req    = imem_req_r;
    assign bus.imem_addr   = imem_addr_r;
    assign bus.instr_valid = instr_valid_r;
    assign bus.instr_out   = instr_out_r;
    assign bus.instr_pc    = instr_pc_r;

endmodule
